// File: rtl/tm_entry_sequencer.sv
// tm_entry_sequencer: input front end for the Turing machine core.
// Debounces the Next/Done buttons and assembles rules and tape bits from the switches.
// Ports: clock, reset (sync, active low), input_data, next_btn, done_btn ->
//        phase, field_idx, rule_write/addr/data, tape_write/addr/bit,
//        run_start, step, prog_full, tape_full.
module tm_entry_sequencer #(
    parameter int DATA_W          = 6,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int RULE_DEPTH      = 16,
    parameter int TAPE_DEPTH      = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             input_data,
    input  logic                          next_btn,
    input  logic                          done_btn,
    output logic [1:0]                    phase,
    output logic [1:0]                    field_idx,
    output logic                          rule_write,
    output logic [$clog2(RULE_DEPTH)-1:0] rule_addr,
    output logic [DATA_W+2:0]             rule_data,
    output logic                          tape_write,
    output logic [$clog2(TAPE_DEPTH)-1:0] tape_addr,
    output logic                          tape_bit,
    output logic                          run_start,
    output logic                          step,
    output logic                          prog_full,
    output logic                          tape_full
);

    localparam int RA_W  = $clog2(RULE_DEPTH);
    localparam int TA_W  = $clog2(TAPE_DEPTH);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        PH_PROG = 2'd0,
        PH_TAPE = 2'd1,
        PH_RUN  = 2'd2
    } phase_e;

    // Button conditioning: bit 0 = Next, bit 1 = Done.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_prev_q, deb_prev_d;
    logic [1:0]            pulse_q, pulse_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d    = {done_btn, next_btn};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        pulse_d    = deb_q & ~deb_prev_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            // The flip is taken the cycle after the count lands on
            // DEBOUNCE_CYCLES, so a press of exactly that length still counts.
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                deb_d[i] = ~deb_q[i];
            end else if (sync2_q[i] != deb_q[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Sequencer state.
    phase_e             phase_q, phase_d;
    logic [1:0]         field_q, field_d;
    logic               sym_q, sym_d;
    logic [1:0]         dir_q, dir_d;
    logic [RA_W:0]      rule_cnt_q, rule_cnt_d;
    logic [TA_W:0]      tape_cnt_q, tape_cnt_d;
    logic               rule_write_q, rule_write_d;
    logic [RA_W-1:0]    rule_addr_q, rule_addr_d;
    logic [DATA_W+2:0]  rule_data_q, rule_data_d;
    logic               tape_write_q, tape_write_d;
    logic [TA_W-1:0]    tape_addr_q, tape_addr_d;
    logic               tape_bit_q, tape_bit_d;
    logic               run_start_q, run_start_d;
    logic               step_q, step_d;

    logic nxt;
    logic dn;
    logic rules_full;
    logic cells_full;

    assign dn         = pulse_q[1];
    assign nxt        = pulse_q[0] & ~pulse_q[1];
    assign rules_full = (rule_cnt_q == (RA_W+1)'(RULE_DEPTH));
    assign cells_full = (tape_cnt_q == (TA_W+1)'(TAPE_DEPTH));

    always_comb begin
        phase_d      = phase_q;
        field_d      = field_q;
        sym_d        = sym_q;
        dir_d        = dir_q;
        rule_cnt_d   = rule_cnt_q;
        tape_cnt_d   = tape_cnt_q;
        rule_write_d = 1'b0;
        rule_addr_d  = rule_addr_q;
        rule_data_d  = rule_data_q;
        tape_write_d = 1'b0;
        tape_addr_d  = tape_addr_q;
        tape_bit_d   = tape_bit_q;
        run_start_d  = 1'b0;
        step_d       = 1'b0;
        unique case (phase_q)
            PH_PROG: begin
                if (dn) begin
                    field_d = 2'd0;
                    phase_d = PH_TAPE;
                end else if (nxt && !rules_full) begin
                    unique case (field_q)
                        2'd0: begin
                            sym_d   = input_data[0];
                            field_d = 2'd1;
                        end
                        2'd1: begin
                            dir_d   = input_data[1:0];
                            field_d = 2'd2;
                        end
                        2'd2: begin
                            rule_write_d = 1'b1;
                            rule_addr_d  = rule_cnt_q[RA_W-1:0];
                            rule_data_d  = {input_data, dir_q, sym_q};
                            rule_cnt_d   = rule_cnt_q + (RA_W+1)'(1);
                            field_d      = 2'd0;
                        end
                        default: field_d = 2'd0;
                    endcase
                end
            end
            PH_TAPE: begin
                if (dn) begin
                    phase_d     = PH_RUN;
                    run_start_d = 1'b1;
                end else if (nxt && !cells_full) begin
                    tape_write_d = 1'b1;
                    tape_bit_d   = input_data[0];
                    tape_addr_d  = tape_cnt_q[TA_W-1:0];
                    tape_cnt_d   = tape_cnt_q + (TA_W+1)'(1);
                end
            end
            PH_RUN: begin
                step_d = nxt;
            end
            default: phase_d = PH_PROG;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            pulse_q      <= '0;
            cnt_q        <= '0;
            phase_q      <= PH_PROG;
            field_q      <= '0;
            sym_q        <= 1'b0;
            dir_q        <= '0;
            rule_cnt_q   <= '0;
            tape_cnt_q   <= '0;
            rule_write_q <= 1'b0;
            rule_addr_q  <= '0;
            rule_data_q  <= '0;
            tape_write_q <= 1'b0;
            tape_addr_q  <= '0;
            tape_bit_q   <= 1'b0;
            run_start_q  <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            pulse_q      <= pulse_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            field_q      <= field_d;
            sym_q        <= sym_d;
            dir_q        <= dir_d;
            rule_cnt_q   <= rule_cnt_d;
            tape_cnt_q   <= tape_cnt_d;
            rule_write_q <= rule_write_d;
            rule_addr_q  <= rule_addr_d;
            rule_data_q  <= rule_data_d;
            tape_write_q <= tape_write_d;
            tape_addr_q  <= tape_addr_d;
            tape_bit_q   <= tape_bit_d;
            run_start_q  <= run_start_d;
            step_q       <= step_d;
        end
    end

    assign phase      = phase_q;
    assign field_idx  = field_q;
    assign rule_write = rule_write_q;
    assign rule_addr  = rule_addr_q;
    assign rule_data  = rule_data_q;
    assign tape_write = tape_write_q;
    assign tape_addr  = tape_addr_q;
    assign tape_bit   = tape_bit_q;
    assign run_start  = run_start_q;
    assign step       = step_q;
    assign prog_full  = rules_full;
    assign tape_full  = cells_full;

endmodule

// File: doc/tm_entry_sequencer.md
Name: tm_entry_sequencer

Overview:
- Front-end stage that feeds the Turing machine core.
- Conditions the raw Next/Done push-buttons: 2-flop synchroniser, debounce, then a single-cycle pulse on each press.
- Uses those pulses to assemble transition-rule records and tape bits from the 6-bit input_data switches, and issues write strobes to rule memory and tape memory.
- Then hands off to run mode, where each Next press becomes a one-cycle step pulse.

Parameters:
- DATA_W, 6, width of input_data and of the next-state field.
- DEBOUNCE_CYCLES, 2, consecutive synchronised-stable cycles required before the debounced level changes.
- RULE_DEPTH, 16, number of rule slots; rule_addr width is log2(RULE_DEPTH).
- TAPE_DEPTH, 64, number of tape cells; tape_addr width is log2(TAPE_DEPTH).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- input_data  in  DATA_W  switch value, sampled when a Next pulse fires.
- next_btn  in  1  raw Next button, asynchronous.
- done_btn  in  1  raw Done button, asynchronous.
- phase  out  2  0=PROG, 1=TAPE, 2=RUN.
- field_idx  out  2  rule field expected next: 0=symbol, 1=direction, 2=next state.
- rule_write  out  1  one-cycle rule memory write strobe.
- rule_addr  out  log2(RULE_DEPTH)  rule slot being written.
- rule_data  out  DATA_W+3  {next_state, dir[1:0], sym}.
- tape_write  out  1  one-cycle tape write strobe.
- tape_addr  out  log2(TAPE_DEPTH)  tape cell being written.
- tape_bit  out  1  tape data.
- run_start  out  1  one-cycle pulse on entry to RUN.
- step  out  1  one-cycle step request in RUN.
- prog_full  out  1  all rule slots used.
- tape_full  out  1  all tape cells used.

Behaviour:
- Reset (reset=0 at a rising edge):
  - All outputs 0, phase=PROG.
  - Synchronisers, debounce counters, debounced levels, rule/tape counters and partial-rule registers cleared.
  - Reset mid-operation discards any partial rule; no strobe is issued in the reset cycle.
- Button conditioning, per button:
  - 2-flop synchroniser feeds a counter that increments while the synchronised value differs from the debounced level; the counter clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A pulse is asserted for exactly one cycle, in the cycle after a debounced 0->1 flip.
  - For a clean press, the pulse appears DEBOUNCE_CYCLES+3 cycles after the first edge sampling the raw input high.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse. Release never produces a pulse.
- Priority: if the Next and Done pulses coincide, Done wins and Next is dropped.
- PROG phase, on a Next pulse (input_data sampled that cycle):
  - field 0: latch sym=input_data[0]; field_idx becomes 1.
  - field 1: latch dir=input_data[1:0], all four values accepted; field_idx becomes 2.
  - field 2: latch next_state=input_data. In the following cycle rule_write=1, rule_data={next_state,dir,sym}, rule_addr=current count. The count then increments and field_idx returns to 0.
  - rule_addr and rule_data hold their last values when rule_write=0.
  - When the count reaches RULE_DEPTH, prog_full=1 and further Next pulses are ignored; the count does not wrap.
- PROG phase, on a Done pulse: a partial rule is discarded, field_idx=0, phase becomes TAPE.
- TAPE phase:
  - On a Next pulse, in the next cycle tape_write=1, tape_bit=input_data[0], tape_addr=current count; then the count increments.
  - When the count reaches TAPE_DEPTH, tape_full=1 and further Next pulses are ignored.
  - On a Done pulse, phase becomes RUN and run_start=1 for one cycle in the following cycle.
- RUN phase:
  - Each Next pulse produces step=1 for one cycle, in the following cycle.
  - Done pulses are ignored.
  - Only reset leaves RUN.
- Strobes: rule_write, tape_write, step and run_start are never high for more than one consecutive cycle.

Test Plan:
- Reset with reset=0 for 2 cycles -> all outputs 0, phase=0, field_idx=0.
- In PROG, Next presses (held 4 cycles each) with input_data=1, 2, 5 -> exactly one rule_write, rule_addr=0, rule_data=9'b000101_10_1. A second triple gives rule_addr=1.
- Next glitch held 1 cycle -> no pulse and field_idx unchanged. Next held 2 cycles -> one pulse DEBOUNCE_CYCLES+3=5 cycles after the rise.
- Two fields entered, then Done -> no rule_write, phase=1, field_idx=0. Then Next with input_data=1, then 0 -> tape_write at tape_addr 0 with bit 1, then tape_addr 1 with bit 0.
- Done and Next pressed simultaneously in TAPE -> phase=2 and run_start pulse, no tape_write. Then 3 Next presses -> 3 single-cycle step pulses.
- 16 rules entered -> prog_full=1; a 17th triple produces no rule_write. Reset mid-RUN (reset=0 for 1 cycle) -> phase=0, all counters 0, no step pulse.
